// File: rtl/pingpong_buffer.sv
// Double-bank ping-pong buffer: a producer fills one bank while a consumer drains the other.
// Define PINGPONG_PARITY_EN to store an even-parity bit per word and add the rd_parity_err output.
module pingpong_buffer #(
   parameter int addrLen = 6,
   parameter int dataLen = 32,
   parameter int memSize = 1 << addrLen,
   parameter int RD_LAT  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wrt,
   input  logic [addrLen-1:0] wrt_addr,
   input  logic [dataLen-1:0] data_in,
   input  logic               wr_done,
   output logic               wr_ready,
   input  logic               rd_en,
   input  logic [addrLen-1:0] rd_addr,
   input  logic               rd_done,
   output logic               rd_ready,
   output logic [addrLen:0]   rd_words,
   output logic [dataLen-1:0] data_out,
   output logic               data_out_valid
`ifdef PINGPONG_PARITY_EN
   ,
   output logic               rd_parity_err
`endif
);

`ifdef PINGPONG_PARITY_EN
   localparam int MW = dataLen + 1;
`else
   localparam int MW = dataLen;
`endif

   localparam logic [addrLen:0] MEM_SIZE_C = memSize[addrLen:0];

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } bank_state_t;

   bank_state_t      r_bank_state [2];
   logic             r_wbank;
   logic             r_rbank;
   logic [addrLen:0] r_fill_cnt [2];
   logic [MW-1:0]    r_mem [2][memSize];

   logic             w_wr_ready;
   logic             w_rd_ready;
   logic             w_wr_accept;
   logic             w_rd_accept;
   logic [MW-1:0]    w_wr_word;
   logic [MW-1:0]    w_rd_word;
   logic [MW-1:0]    w_rd_payload;

   logic             r_vld1;
   logic [MW-1:0]    r_pay1;
   logic             w_out_vld;
   logic [MW-1:0]    w_out_pay;

   assign w_wr_ready  = (r_bank_state[r_wbank] == EMPTY);
   assign w_rd_ready  = (r_bank_state[r_rbank] == FULL);
   assign w_wr_accept = wrt && w_wr_ready;
   assign w_rd_accept = rd_en && w_rd_ready;

   assign wr_ready = w_wr_ready;
   assign rd_ready = w_rd_ready;
   assign rd_words = w_rd_ready ? r_fill_cnt[r_rbank] : '0;

   assign w_rd_word = r_mem[r_rbank][rd_addr];

`ifdef PINGPONG_PARITY_EN
   // Top bit of the stored word is even parity; on read it becomes the error flag.
   assign w_wr_word    = {^data_in, data_in};
   assign w_rd_payload = {^w_rd_word, w_rd_word[dataLen-1:0]};
`else
   assign w_wr_word    = data_in;
   assign w_rd_payload = w_rd_word;
`endif

   // Bank ownership and word counts; wr_done/rd_done always target different banks.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_bank_state[0] <= EMPTY;
         r_bank_state[1] <= EMPTY;
         r_wbank         <= 1'b0;
         r_rbank         <= 1'b0;
         r_fill_cnt[0]   <= '0;
         r_fill_cnt[1]   <= '0;
      end else begin
         if (w_wr_accept && (r_fill_cnt[r_wbank] != MEM_SIZE_C))
            r_fill_cnt[r_wbank] <= r_fill_cnt[r_wbank] + 1'b1;
         if (wr_done && w_wr_ready) begin
            r_bank_state[r_wbank] <= FULL;
            r_wbank               <= ~r_wbank;
         end
         if (rd_done && w_rd_ready) begin
            r_bank_state[r_rbank] <= EMPTY;
            r_fill_cnt[r_rbank]   <= '0;
            r_rbank               <= ~r_rbank;
         end
      end
   end

   // NOTE: storage array has no reset so it maps onto plain RAM; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_wr_accept)
         r_mem[r_wbank][wrt_addr] <= w_wr_word;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_vld1 <= 1'b0;
         r_pay1 <= '0;
      end else begin
         r_vld1 <= w_rd_accept;
         if (w_rd_accept)
            r_pay1 <= w_rd_payload;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic          r_vld2;
         logic [MW-1:0] r_pay2;

         always_ff @(posedge clk) begin
            if (!reset) begin
               r_vld2 <= 1'b0;
               r_pay2 <= '0;
            end else begin
               r_vld2 <= r_vld1;
               if (r_vld1)
                  r_pay2 <= r_pay1;
            end
         end

         assign w_out_vld = r_vld2;
         assign w_out_pay = r_pay2;
      end else begin : g_lat1
         assign w_out_vld = r_vld1;
         assign w_out_pay = r_pay1;
      end
   endgenerate

   assign data_out       = w_out_pay[dataLen-1:0];
   assign data_out_valid = w_out_vld;
`ifdef PINGPONG_PARITY_EN
   assign rd_parity_err  = w_out_pay[dataLen] & w_out_vld;
`endif

endmodule

// File: tb/tb_pingpong_buffer.sv
// Self-checking bench for pingpong_buffer: two instances (RD_LAT=1 and RD_LAT=2) share stimulus,
// reads are scoreboarded per instance. Parity checks run when PINGPONG_PARITY_EN is defined.
module tb_pingpong_buffer;

   localparam int AW = 6;
   localparam int DW = 32;

   typedef struct {
      logic [DW-1:0] data;
      int            due;
      logic          perr;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          wrt;
   logic [AW-1:0] wrt_addr;
   logic [DW-1:0] data_in;
   logic          wr_done;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          rd_done;

   logic          wr_ready1, wr_ready2, rd_ready1, rd_ready2;
   logic [AW:0]   rd_words1, rd_words2;
   logic [DW-1:0] dout1, dout2;
   logic          vld1, vld2;
   logic          perr1, perr2;

   int            n_tests = 0;
   int            n_fail  = 0;
   int            cyc     = 0;
   exp_t          q1[$];
   exp_t          q2[$];
   logic [DW-1:0] last1, last2;
   logic [DW-1:0] mdl [2][64];
   int            m_wbank = 0;
   int            m_rbank = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pingpong_buffer #(.addrLen(AW), .dataLen(DW), .RD_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset), .wrt(wrt), .wrt_addr(wrt_addr), .data_in(data_in),
      .wr_done(wr_done), .wr_ready(wr_ready1), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_done(rd_done), .rd_ready(rd_ready1), .rd_words(rd_words1),
      .data_out(dout1), .data_out_valid(vld1)
`ifdef PINGPONG_PARITY_EN
      , .rd_parity_err(perr1)
`endif
   );

   pingpong_buffer #(.addrLen(AW), .dataLen(DW), .RD_LAT(2)) u_dut2 (
      .clk(clk), .reset(reset), .wrt(wrt), .wrt_addr(wrt_addr), .data_in(data_in),
      .wr_done(wr_done), .wr_ready(wr_ready2), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_done(rd_done), .rd_ready(rd_ready2), .rd_words(rd_words2),
      .data_out(dout2), .data_out_valid(vld2)
`ifdef PINGPONG_PARITY_EN
      , .rd_parity_err(perr2)
`endif
   );

`ifndef PINGPONG_PARITY_EN
   assign perr1 = 1'b0;
   assign perr2 = 1'b0;
`endif

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_state(input string tag, input logic wr, input logic rr, input int words);
      check({tag, "_wr_ready1"}, wr_ready1, wr);
      check({tag, "_wr_ready2"}, wr_ready2, wr);
      check({tag, "_rd_ready1"}, rd_ready1, rr);
      check({tag, "_rd_ready2"}, rd_ready2, rr);
      check({tag, "_rd_words1"}, rd_words1, words);
      check({tag, "_rd_words2"}, rd_words2, words);
   endtask

   // One write cycle; 'acc' says whether the bench expects the DUT to accept it.
   task automatic wr(input int a, input logic [DW-1:0] d, input logic done, input logic acc);
      wrt = 1'b1; wrt_addr = AW'(a); data_in = d; wr_done = done;
      if (acc) mdl[m_wbank][a] = d;
      tick();
      wrt = 1'b0; wr_done = 1'b0;
      if (acc && done) m_wbank ^= 1;
   endtask

   // One accepted read; expectation goes to the RD_LAT=1 queue and optionally the RD_LAT=2 queue.
   task automatic rd(input int a, input logic done, input logic to2, input logic pe);
      exp_t e;
      rd_en = 1'b1; rd_addr = AW'(a); rd_done = done;
      e.data = mdl[m_rbank][a]; e.perr = pe;
      e.due = cyc + 1; q1.push_back(e);
      if (to2) begin
         e.due = cyc + 2; q2.push_back(e);
      end
      tick();
      rd_en = 1'b0; rd_done = 1'b0;
      if (done) m_rbank ^= 1;
   endtask

   always @(posedge clk) begin
      if (!reset) begin
         last1 <= '0;
         last2 <= '0;
      end
   end

   // Output monitor: every negedge, each instance either delivers the queue head on time or holds.
   always @(negedge clk) begin
      exp_t e;
      if (vld1) begin
         if (q1.size() == 0) check("lat1_spurious_valid", 1, 0);
         else begin
            e = q1.pop_front();
            check("lat1_data", dout1, e.data);
            check("lat1_latency", cyc, e.due);
`ifdef PINGPONG_PARITY_EN
            check("lat1_perr", perr1, e.perr);
`endif
            last1 = e.data;
         end
      end else begin
         if (q1.size() != 0 && q1[0].due < cyc) begin
            check("lat1_missing_valid", 0, 1);
            void'(q1.pop_front());
         end
         check("lat1_hold", dout1, last1);
      end
      if (vld2) begin
         if (q2.size() == 0) check("lat2_spurious_valid", 1, 0);
         else begin
            e = q2.pop_front();
            check("lat2_data", dout2, e.data);
            check("lat2_latency", cyc, e.due);
`ifdef PINGPONG_PARITY_EN
            check("lat2_perr", perr2, e.perr);
`endif
            last2 = e.data;
         end
      end else begin
         if (q2.size() != 0 && q2[0].due < cyc) begin
            check("lat2_missing_valid", 0, 1);
            void'(q2.pop_front());
         end
         check("lat2_hold", dout2, last2);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; wrt = 1'b0; wrt_addr = '0; data_in = '0; wr_done = 1'b0;
      rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
      repeat (3) tick();
      reset = 1'b1;

      // Reset state; a read and rd_done with no FULL bank are ignored.
      chk_state("reset", 1'b1, 1'b0, 0);
      check("reset_dout1", dout1, 0);
      check("reset_dout2", dout2, 0);
      check("reset_vld1", vld1, 0);
      check("reset_vld2", vld2, 0);
      rd_en = 1'b1; rd_done = 1'b1;
      tick();
      rd_en = 1'b0; rd_done = 1'b0;
      chk_state("idle_rd", 1'b1, 1'b0, 0);

      // Fill bank 0, hand it over, read back.
      for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i, 1'b0, 1'b1);
      wr_done = 1'b1;
      tick();
      wr_done = 1'b0;
      m_wbank = 1;
      chk_state("bank0_full", 1'b1, 1'b1, 4);
      rd(2, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();

      // Fill bank 1, last write coincides with wr_done; both banks FULL.
      for (int i = 0; i < 8; i++) wr(i, 32'hB0 + i, (i == 7), 1'b1);
      chk_state("both_full", 1'b0, 1'b1, 4);
      wr(0, 32'hFF, 1'b1, 1'b0);
      chk_state("dropped_wr", 1'b0, 1'b1, 4);
      rd(1, 1'b1, 1'b1, 1'b0);
      chk_state("bank1_drain", 1'b1, 1'b1, 8);
      rd(0, 1'b0, 1'b1, 1'b0);
      rd(7, 1'b0, 1'b1, 1'b0);

      // Overfill bank 0 (count saturates), then wr_done + rd_done + read together.
      for (int i = 0; i < 70; i++) wr(i % 64, 32'hC00 + i, 1'b0, 1'b1);
      wr_done = 1'b1;
      rd(3, 1'b1, 1'b1, 1'b0);
      wr_done = 1'b0;
      m_wbank = 1;
      chk_state("swap", 1'b1, 1'b1, 64);
      rd(5, 1'b0, 1'b1, 1'b0);
      rd(63, 1'b0, 1'b1, 1'b0);
      repeat (3) tick();

      // Reset while the RD_LAT=2 instance still has the read in its second stage.
      rd(10, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_wbank = 0; m_rbank = 0;
      chk_state("mid_reset", 1'b1, 1'b0, 0);
      check("mid_reset_vld2", vld2, 0);
      check("mid_reset_dout2", dout2, 0);
      repeat (3) tick();

`ifdef PINGPONG_PARITY_EN
      wr(3, 32'h1234_5678, 1'b0, 1'b1);
      wr(4, 32'h0F0F_0F0F, 1'b1, 1'b1);
      u_dut1.r_mem[0][3] = u_dut1.r_mem[0][3] ^ 33'd1;
      u_dut2.r_mem[0][3] = u_dut2.r_mem[0][3] ^ 33'd1;
      mdl[0][3] = 32'h1234_5679;
      rd(3, 1'b0, 1'b1, 1'b1);
      rd(4, 1'b0, 1'b1, 1'b0);
`endif

      repeat (4) tick();
      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pingpong_buffer.md
Name: pingpong_buffer

Overview:
Parametrised double-bank (ping-pong) successor to the single-bank scratch buffer. A producer fills one bank while a consumer drains the other. Bank ownership changes through a done-pulse handshake on each side. Adds per-bank full/empty state, word counting, a selectable read latency and a read-valid strobe; it sits between the memory interface and the PE data paths.

Parameters:
addrLen, 6, address width per bank
dataLen, 32, word width in bits
memSize, 1 << addrLen, words per bank (must be ≤ 2^addrLen)
RD_LAT, 1, read latency in cycles, legal values 1 or 2

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on clk edge)
wrt  input  1  write strobe into current fill bank
wrt_addr  input  addrLen  write address within fill bank
data_in  input  dataLen  write data
wr_done  input  1  producer pulse: fill bank complete, hand to consumer
wr_ready  output  1  fill bank is EMPTY and accepts writes
rd_en  input  1  read strobe from current drain bank
rd_addr  input  addrLen  read address within drain bank
rd_done  input  1  consumer pulse: drain bank consumed, return to producer
rd_ready  output  1  drain bank is FULL and readable
rd_words  output  addrLen+1  accepted-write count of the current drain bank
data_out  output  dataLen  read data
data_out_valid  output  1  data_out carries a new read result this cycle

Behaviour:
- State: bank_state[1:0], each EMPTY or FULL; wbank and rbank are 1-bit bank pointers; fill_cnt[1:0] has addrLen+1 bits per bank.
- Reset values: both banks EMPTY, wbank=rbank=0, fill_cnt=0, data_out=0, data_out_valid=0, pipeline registers 0. Memory contents are not cleared.
- wr_ready = (bank_state[wbank]==EMPTY).
- rd_ready = (bank_state[rbank]==FULL).
- rd_words = fill_cnt[rbank] when rd_ready, else 0.
- Write acceptance: wrt && wr_ready writes data_in to mem[wbank][wrt_addr] and increments fill_cnt[wbank], saturating at memSize. When wr_ready=0, writes are dropped with no state change.
- wr_done && wr_ready: bank_state[wbank] <= FULL and wbank toggles. When wr_ready=0, wr_done is ignored.
- A wrt in the same cycle as wr_done is still committed and counted for the bank being closed.
- Read: rd_en && rd_ready reads mem[rbank][rd_addr].
  - RD_LAT=1: data_out and data_out_valid=1 appear on the next edge.
  - RD_LAT=2: a second register stage is added, so data appears two edges later.
  - With no accepted read, data_out holds its last value and data_out_valid=0.
- rd_done && rd_ready: bank_state[rbank] <= EMPTY, fill_cnt[rbank] <= 0, and rbank toggles. When rd_ready=0, rd_done is ignored.
- A read issued in the same cycle as rd_done still completes; its data already in flight is delivered normally.
- Simultaneous wr_done and rd_done: they always target different banks (one is EMPTY, the other FULL), so both apply in the same cycle.
- Both banks FULL: wr_ready=0 until rd_done.
- Both banks EMPTY: rd_ready=0.
- No read-during-write hazard: reads and writes always target different banks.
- Reset mid-operation: all bank state and the read pipeline are discarded on that edge. data_out_valid=0 on the following cycle.

Optional Feature:
PINGPONG_PARITY_EN
- Defined:
  - Each stored word carries one extra even-parity bit computed from data_in on write.
  - On read, parity is recomputed and output rd_parity_err (1 bit) is asserted, aligned with data_out_valid, on mismatch.
  - rd_parity_err resets to 0.
- Undefined: no parity storage and no rd_parity_err port.

Test Plan:
1. Reset released → wr_ready=1, rd_ready=0, rd_words=0, data_out=0, data_out_valid=0.
2. Write addrs 0..3 with 0xA0..0xA3, then pulse wr_done → rd_ready=1, rd_words=4, wr_ready=1 (bank 1). Read addr 2 → data_out=0xA2 with data_out_valid after RD_LAT cycles (run with RD_LAT=1 and RD_LAT=2).
3. Fill bank 1 with 0xB0..0xB7 and wr_done while bank 0 is still undrained → wr_ready=0. A further wrt of 0xFF to addr 0 is dropped. After rd_done, reading addr 0 returns 0xB0 with rd_words=8.
4. wr_done and rd_done in the same cycle (bank 1 filling, bank 0 draining) → bank 1 becomes FULL and bank 0 EMPTY simultaneously; rd_ready=1, wr_ready=1, rd_words equals bank 1's count.
5. Assert reset=0 for one cycle while a read is in flight and one bank is FULL → no data_out_valid pulse, wr_ready=1, rd_ready=0, rd_words=0.
6. With PINGPONG_PARITY_EN: force-corrupt a stored bit via hierarchical access and read it → rd_parity_err=1 with data_out_valid. A clean word gives rd_parity_err=0.
